// File: rtl/sw_debounce.sv
// Switch conditioning: two-flop synchronizer, per-bit stability counter,
// debounced levels and registered one-cycle rise/fall/changed pulses.
module sw_debounce #(
    parameter int N       = 10,
    parameter int CNT_MAX = 500000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_clean,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic         changed
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);

    logic [N-1:0]  sync1_q, sync1_d;
    logic [N-1:0]  sync2_q, sync2_d;
    logic [N-1:0]  clean_q, clean_d;
    logic [N-1:0]  rise_q, rise_d;
    logic [N-1:0]  fall_q, fall_d;
    logic          changed_q, changed_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    // A bit is pending whenever the synchronized level disagrees with the
    // accepted level; any agreement (a bounce) drops the count back to zero.
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == LAST) begin
                    clean_d[i] = sync2_q[i];
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_clean = clean_q;
    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with N=10, CNT_MAX=4 (acceptance on edge 6).
module tb_sw_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sw_raw;
    logic [9:0] sw_clean;
    logic [9:0] sw_rise;
    logic [9:0] sw_fall;
    logic       changed;

    int errors = 0;
    int checks = 0;

    sw_debounce #(.N(10), .CNT_MAX(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges 1..5 must leave outputs quiet; edge 6 accepts; edge 7 clears pulses.
    task automatic expect6(input string tag, input logic [9:0] old_c,
                           input logic [9:0] new_c, input logic [9:0] er,
                           input logic [9:0] ef);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k < 6) begin
                check({tag, " hold clean"}, sw_clean, old_c);
                check({tag, " hold rise"}, sw_rise, 0);
                check({tag, " hold fall"}, sw_fall, 0);
                check({tag, " hold chg"}, changed, 0);
            end else begin
                check({tag, " clean"}, sw_clean, new_c);
                check({tag, " rise"}, sw_rise, er);
                check({tag, " fall"}, sw_fall, ef);
                check({tag, " chg"}, changed, |(er | ef));
            end
        end
        step();
        check({tag, " post clean"}, sw_clean, new_c);
        check({tag, " post rise"}, sw_rise, 0);
        check({tag, " post fall"}, sw_fall, 0);
        check({tag, " post chg"}, changed, 0);
    endtask

    task automatic apply(input string tag, input logic [9:0] raw,
                         input logic [9:0] old_c, input logic [9:0] new_c,
                         input logic [9:0] er, input logic [9:0] ef);
        sw_raw = raw;
        expect6(tag, old_c, new_c, er, ef);
    endtask

    task automatic quiet(input string tag, input logic [9:0] c);
        check({tag, " clean"}, sw_clean, c);
        check({tag, " rise"}, sw_rise, 0);
        check({tag, " fall"}, sw_fall, 0);
        check({tag, " chg"}, changed, 0);
    endtask

    initial begin
        rst    = 1'b1;
        sw_raw = 10'h3FF;
        step();
        quiet("rst1", 10'h000);
        step();
        quiet("rst2", 10'h000);
        rst = 1'b0;
        expect6("rel", 10'h000, 10'h3FF, 10'h3FF, 10'h000);

        apply("all0", 10'h000, 10'h3FF, 10'h000, 10'h000, 10'h3FF);
        apply("press", 10'h001, 10'h000, 10'h001, 10'h001, 10'h000);
        apply("release", 10'h000, 10'h001, 10'h000, 10'h000, 10'h001);

        for (int p = 0; p < 4; p++) begin
            sw_raw = (p % 2 == 0) ? 10'h002 : 10'h000;
            for (int c = 0; c < 2; c++) begin
                step();
                quiet("bounce", 10'h000);
            end
        end
        for (int c = 0; c < 8; c++) begin
            step();
            quiet("bounce hold", 10'h000);
        end

        sw_raw = 10'h004;
        step();
        quiet("settle b1", 10'h000);
        sw_raw = 10'h000;
        step();
        quiet("settle b2", 10'h000);
        apply("settle", 10'h004, 10'h000, 10'h004, 10'h004, 10'h000);

        apply("b9 up", 10'h204, 10'h004, 10'h204, 10'h200, 10'h000);
        apply("simul", 10'h005, 10'h204, 10'h005, 10'h001, 10'h200);

        sw_raw = 10'h00D;
        for (int c = 0; c < 3; c++) begin
            step();
            quiet("mid cnt", 10'h005);
        end
        rst = 1'b1;
        step();
        quiet("mid rst", 10'h000);
        rst = 1'b0;
        expect6("mid rel", 10'h000, 10'h00D, 10'h00D, 10'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
